buffer_stream_ctrl: RTL and testbench

Controller and arbiter for one `buffer` instance in the matrix-multiply datapath. It shares the buffer between a host write port and a streaming reader that feeds the PE array. On a start command it sequences buffer reads from a base address for a programmed length and absorbs the buffer's 1-cycle read latency behind a small FIFO. It presents the bytes as a valid/ready stream, and it blocks host writes while a stream is in progress.

---
 rtl/buffer_pkg.sv | 16 +
 rtl/buffer_stream_ctrl_if.sv | 53 +++++
 rtl/stream_fifo.sv | 51 +++++
 rtl/buffer_stream_ctrl.sv | 142 ++++++++++++++
 tb/tb_buffer_stream_ctrl.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/buffer_pkg.sv
// Shared types and default sizes for the buffer
// and its stream controller.
package buffer_pkg;

  localparam int DEPTH      = 32;
  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int SKID_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/buffer_stream_ctrl_if.sv
// Host, stream and buffer-port signals of the
// buffer stream controller.
interface buffer_stream_ctrl_if
  import buffer_pkg::*;
#(
  parameter int AddrWidth = ADDR_WIDTH,
  parameter int DataWidth = DATA_WIDTH
);

  logic                 start;
  logic                 startReady;
  logic [AddrWidth-1:0] baseAddr;
  logic [AddrWidth:0]   length;
  logic [DataWidth-1:0] outData;
  logic                 outValid;
  logic                 outReady;
  logic                 done;
  logic                 writeReq;
  logic [AddrWidth-1:0] writeAddr;
  logic [DataWidth-1:0] writeData;
  logic                 writeGnt;
  logic                 bufWriteEn;
  logic [AddrWidth-1:0] bufWriteAddr;
  logic [DataWidth-1:0] bufDataIn;
  logic                 bufReadEn;
  logic [AddrWidth-1:0] bufReadAddr;
  logic [DataWidth-1:0] bufDataOut;

  modport slave (
    input  start, baseAddr, length,
    input  outReady, writeReq,
    input  writeAddr, writeData,
    input  bufDataOut,
    output startReady, outData, outValid,
    output done, writeGnt,
    output bufWriteEn, bufWriteAddr,
    output bufDataIn,
    output bufReadEn, bufReadAddr
  );

  modport master (
    output start, baseAddr, length,
    output outReady, writeReq,
    output writeAddr, writeData,
    output bufDataOut,
    input  startReady, outData, outValid,
    input  done, writeGnt,
    input  bufWriteEn, bufWriteAddr,
    input  bufDataIn,
    input  bufReadEn, bufReadAddr
  );

endinterface

// File: rtl/stream_fifo.sv
// Small synchronous FIFO that holds read data
// until the stream consumer takes it.
module stream_fifo #(
  parameter int SkidDepth = 4,
  parameter int DataWidth = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [DataWidth-1:0] push_data,
  input  logic                 pop,
  output logic [DataWidth-1:0] head,
  output logic [$clog2(SkidDepth):0] count,
  output logic                 empty,
  output logic                 full
);

  localparam int PtrW = $clog2(SkidDepth);
  localparam int CntW = PtrW + 1;

  logic [DataWidth-1:0] mem [SkidDepth];
  logic [PtrW-1:0]      wr_ptr;
  logic [PtrW-1:0]      rd_ptr;

  // pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PtrW'(1);
      if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
      count <= count + CntW'(push)
                     - CntW'(pop);
    end
  end

  // storage needs no reset; head is masked when empty
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // status and head view
  always_comb begin
    empty = (count == '0);
    full  = (count == CntW'(SkidDepth));
    head  = empty ? '0 : mem[rd_ptr];
  end

endmodule

// File: rtl/buffer_stream_ctrl.sv
// Shares one buffer between host writes and a
// credit-limited read stream toward the PE array.
module buffer_stream_ctrl
  import buffer_pkg::*;
#(
  parameter int Depth     = DEPTH,
  parameter int DataWidth = DATA_WIDTH,
  parameter int AddrWidth = $clog2(Depth),
  parameter int SkidDepth = SKID_DEPTH
) (
  input logic clk,
  input logic rst,
  buffer_stream_ctrl_if.slave bus
);

  localparam int CntW = $clog2(SkidDepth) + 1;
  localparam int LenW = AddrWidth + 1;

  state_t               state;
  state_t               state_nx;
  logic [AddrWidth-1:0] addr;
  logic [LenW-1:0]      remaining;
  logic [1:0]           inflight;
  logic                 rd_pend;
  logic                 done_q;
  logic                 done_nx;

  logic [DataWidth-1:0] head;
  logic [CntW-1:0]      count;
  logic                 empty;
  logic                 full;

  logic accept;
  logic credit_ok;
  logic issue;
  logic push;
  logic pop;
  logic drained;

  stream_fifo #(
    .SkidDepth (SkidDepth),
    .DataWidth (DataWidth)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (bus.bufDataOut),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  // issue credit, handshake and drain detection
  always_comb begin
    accept    = (state == IDLE) && bus.start;
    credit_ok = !full &&
                ((int'(count) + int'(inflight))
                 < SkidDepth);
    issue     = (state == READ) &&
                (remaining != '0) && credit_ok;
    push      = rd_pend;
    pop       = !empty && bus.outReady;
    drained   = (remaining == '0) &&
                (inflight == '0) &&
                (empty ||
                 ((count == CntW'(1)) && pop));
  end

  // next state and completion pulse
  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.length != '0) begin
            state_nx = READ;
          end else begin
            done_nx = 1'b1;
          end
        end
      end
      READ: begin
        if (issue &&
            (remaining == LenW'(1))) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (drained) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // state, address/length counters, in-flight reads
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      inflight  <= '0;
      rd_pend   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state    <= state_nx;
      done_q   <= done_nx;
      rd_pend  <= issue;
      inflight <= inflight + 2'(issue)
                           - 2'(push);
      if (accept) begin
        addr      <= bus.baseAddr;
        remaining <= bus.length;
      end else if (issue) begin
        addr      <= addr + AddrWidth'(1);
        remaining <= remaining - LenW'(1);
      end
    end
  end

  // stream, buffer-port and arbitration outputs
  always_comb begin
    bus.startReady   = (state == IDLE);
    bus.outValid     = !empty;
    bus.outData      = head;
    bus.done         = done_q;
    bus.bufReadEn    = issue;
    bus.bufReadAddr  = addr;
    bus.writeGnt     = bus.writeReq &&
                       (state == IDLE) &&
                       !bus.start;
    bus.bufWriteEn   = bus.writeGnt;
    bus.bufWriteAddr = bus.writeAddr;
    bus.bufDataIn    = bus.writeData;
  end

endmodule

// File: tb/tb_buffer_stream_ctrl.sv
// Directed bench for buffer_stream_ctrl with a
// behavioural 32x8 buffer on its ports.
module tb_buffer_stream_ctrl;

  localparam int AW = 5;
  localparam int LW = 6;
  localparam int DW = 8;

  logic clk;
  logic rst;

  buffer_stream_ctrl_if #(
    .AddrWidth (AW),
    .DataWidth (DW)
  ) bus ();

  buffer_stream_ctrl #(
    .Depth     (32),
    .DataWidth (DW),
    .AddrWidth (AW),
    .SkidDepth (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] mem [32];
  logic [DW-1:0] rdata;
  logic [DW-1:0] exp_mem [32];

  // buffer model: write port and registered read
  always @(posedge clk) begin
    if (bus.bufWriteEn)
      mem[bus.bufWriteAddr] <= bus.bufDataIn;
    if (bus.bufReadEn)
      rdata <= mem[bus.bufReadAddr];
  end
  assign bus.bufDataOut = rdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] beats[$];
  int raddrs[$];
  int done_cyc, first_beat, last_beat;
  int first_rd, max_ahead, stall_bad;
  int gnt_early;
  logic gnt_done, sr_c1, sr_done;
  logic start_gnt;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input int a,
                            input logic [7:0] d);
    bus.writeReq  = 1'b1;
    bus.writeAddr = AW'(a);
    bus.writeData = d;
    #1;
    chk("idle_gnt", 32'(bus.writeGnt), 1);
    tick();
    bus.writeReq = 1'b0;
    exp_mem[a] = d;
  endtask

  function automatic logic ready_at(input int mode,
                                    input int c);
    if (mode == 0) return 1'b1;
    if (c <= 12) return c[0];
    if (c <= 22) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_stream(input int base,
                            input int len,
                            input int mode,
                            input int mid);
    logic [DW-1:0] prev_d;
    logic prev_stall;
    int ahead;
    beats.delete();
    raddrs.delete();
    done_cyc = -1; first_beat = -1;
    last_beat = -1; first_rd = -1;
    max_ahead = 0; stall_bad = 0;
    gnt_early = 0; gnt_done = 0;
    sr_c1 = 1'b1; sr_done = 1'b0;
    prev_stall = 1'b0; prev_d = '0;
    bus.baseAddr = AW'(base);
    bus.length   = LW'(len);
    bus.start    = 1'b1;
    bus.outReady = 1'b1;
    #1;
    start_gnt = bus.writeGnt;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 200 && done_cyc < 0; c++) begin
      bus.outReady = ready_at(mode, c);
      bus.start = (mid != 0) && (c == mid);
      if (bus.start) begin
        bus.baseAddr = AW'(base + 9);
        bus.length   = LW'(3);
      end
      #1;
      if (c == 1) sr_c1 = bus.startReady;
      if (prev_stall &&
          (!bus.outValid ||
           bus.outData !== prev_d))
        stall_bad++;
      prev_stall = bus.outValid && !bus.outReady;
      prev_d = bus.outData;
      if (bus.bufReadEn) begin
        raddrs.push_back(int'(bus.bufReadAddr));
        if (first_rd < 0) first_rd = c;
      end
      ahead = raddrs.size() - beats.size();
      if (ahead > max_ahead) max_ahead = ahead;
      if (bus.outValid && bus.outReady) begin
        beats.push_back(bus.outData);
        if (first_beat < 0) first_beat = c;
        last_beat = c;
      end
      if (bus.writeGnt && !bus.done) gnt_early++;
      if (bus.done) begin
        done_cyc = c;
        gnt_done = bus.writeGnt;
        sr_done  = bus.startReady;
      end
      tick();
    end
    bus.start = 1'b0;
  endtask

  task automatic check_data(input string tag,
                            input int base,
                            input int len);
    chk({tag, "_count"}, beats.size(), len);
    for (int i = 0; i < len && i < beats.size(); i++)
      chk(tag, 32'(beats[i]),
          32'(exp_mem[(base + i) % 32]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no summary reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.baseAddr = '0;
    bus.length = '0;
    bus.outReady = 1'b0;
    bus.writeReq = 1'b0;
    bus.writeAddr = '0;
    bus.writeData = '0;
    tick();
    tick();
    rst = 1'b0;

    // reset state
    chk("rst_valid", 32'(bus.outValid), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_rden", 32'(bus.bufReadEn), 0);
    chk("rst_wren", 32'(bus.bufWriteEn), 0);
    chk("rst_gnt", 32'(bus.writeGnt), 0);
    chk("rst_srdy", 32'(bus.startReady), 1);
    chk("rst_raddr", 32'(bus.bufReadAddr), 0);
    chk("rst_data", 32'(bus.outData), 0);

    for (int i = 0; i < 32; i++)
      host_write(i, 8'((i * 7 + 3) & 8'hff));

    // basic stream
    for (int i = 0; i < 8; i++)
      host_write(i, 8'(8'h10 + i));
    run_stream(0, 8, 0, 0);
    check_data("basic", 0, 8);
    chk("basic_first_rd", first_rd, 1);
    chk("basic_first", first_beat, 3);
    chk("basic_last", last_beat, 10);
    chk("basic_done", done_cyc, 11);
    chk("basic_srdy_c1", 32'(sr_c1), 0);
    chk("basic_srdy_done", 32'(sr_done), 1);

    // address wrap
    host_write(30, 8'hA0);
    host_write(31, 8'hA1);
    host_write(0, 8'hB0);
    host_write(1, 8'hB1);
    run_stream(30, 4, 0, 0);
    check_data("wrap", 30, 4);
    chk("wrap_nrd", raddrs.size(), 4);
    if (raddrs.size() == 4) begin
      chk("wrap_a0", raddrs[0], 30);
      chk("wrap_a1", raddrs[1], 31);
      chk("wrap_a2", raddrs[2], 0);
      chk("wrap_a3", raddrs[3], 1);
    end
    chk("wrap_done", done_cyc, 7);

    // backpressure
    run_stream(16, 16, 1, 0);
    check_data("bp", 16, 16);
    chk("bp_stable", stall_bad, 0);
    chk("bp_ahead", 32'(max_ahead <= 4), 1);
    chk("bp_nrd", raddrs.size(), 16);
    chk("bp_done_seen", 32'(done_cyc > 0), 1);

    // write arbitration during a stream
    bus.writeReq  = 1'b1;
    bus.writeAddr = AW'(5);
    bus.writeData = 8'hEE;
    run_stream(0, 8, 0, 0);
    bus.writeReq = 1'b0;
    chk("arb_start_gnt", 32'(start_gnt), 0);
    chk("arb_first_rd", first_rd, 1);
    check_data("arb", 0, 8);
    chk("arb_gnt_early", gnt_early, 0);
    chk("arb_gnt_done", 32'(gnt_done), 1);
    chk("arb_done", done_cyc, 11);
    exp_mem[5] = 8'hEE;

    // zero length
    run_stream(3, 0, 0, 0);
    chk("zero_done", done_cyc, 1);
    chk("zero_nrd", raddrs.size(), 0);
    chk("zero_beats", beats.size(), 0);

    // start ignored mid-stream
    run_stream(0, 8, 0, 4);
    check_data("ign", 0, 8);
    chk("ign_nrd", raddrs.size(), 8);
    chk("ign_done", done_cyc, 11);
    tick();
    chk("ign_idle_rden", 32'(bus.bufReadEn), 0);

    // reset mid-stream
    bus.baseAddr = AW'(0);
    bus.length   = LW'(20);
    bus.start    = 1'b1;
    bus.outReady = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_srdy", 32'(bus.startReady), 1);
    chk("mrst_valid", 32'(bus.outValid), 0);
    chk("mrst_done", 32'(bus.done), 0);
    chk("mrst_rden", 32'(bus.bufReadEn), 0);
    chk("mrst_raddr", 32'(bus.bufReadAddr), 0);
    chk("mrst_data", 32'(bus.outData), 0);
    tick();
    chk("mrst_valid2", 32'(bus.outValid), 0);

    // fresh stream after reset
    run_stream(10, 6, 0, 0);
    check_data("fresh", 10, 6);
    chk("fresh_first", first_beat, 3);
    chk("fresh_done", done_cyc, 9);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
